// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the Execute stage: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle combinational multiplier.
module ex_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [6:0]      ex_funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned AW = 2 * XLEN;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_M   = 7'b0000001;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q;
  logic [XLEN-1:0]   opb_q;
  logic [2:0]        f3_q;
  logic              neg_a_q, neg_b_q;
  logic              special_q;
  logic [XLEN-1:0]   special_res_q;
  logic [CW-1:0]     cnt_q;

  logic            start;
  logic            is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  // Decode, operand magnitudes and start-time special cases
  always_comb begin
    start    = ex_valid & ~flush & (ex_opcode == OPC_OP) & (ex_funct7 == F7_M) & (state_q == IDLE);
    is_div   = ex_funct3[2];
    sgn_a    = is_div ? ~ex_funct3[0] : (ex_funct3[1:0] != 2'b11);
    sgn_b    = is_div ? ~ex_funct3[0] : ~ex_funct3[1];
    neg_a    = sgn_a & op_a[XLEN-1];
    neg_b    = sgn_b & op_b[XLEN-1];
    abs_a    = neg_a ? -op_a : op_a;
    abs_b    = neg_b ? -op_b : op_b;
    div_zero = is_div & (op_b == '0);
    div_ovf  = is_div & sgn_a & (op_a == INT_MIN) & (op_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = ex_funct3[1] ? op_a : '1;
    else          special_res = ex_funct3[1] ? '0 : INT_MIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [AW-1:0] fast_mag, fast_prod;
  always_comb begin
    fast      = ~is_div;
    fast_mag  = AW'(abs_a) * AW'(abs_b);
    fast_prod = (neg_a ^ neg_b) ? -fast_mag : fast_mag;
    fast_res  = (ex_funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[AW-1:XLEN];
  end
`else
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
  end
`endif

  // One iteration of shift-add multiply and restoring divide
  logic [XLEN:0]   mul_sum, div_part, div_trial;
  logic [AW-1:0]   mul_nxt, div_nxt;
  always_comb begin
    mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    div_part  = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_part - {1'b0, opb_q};
    if (!div_trial[XLEN]) div_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                  div_nxt = {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign fix-up of the accumulated magnitude
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quot, rem, done_res;
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot = acc_q[XLEN-1:0];
    rem  = acc_q[AW-1:XLEN];
    if (special_q)                  done_res = special_res_q;
    else if (!f3_q[2])              done_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[AW-1:XLEN];
    else if (f3_q[1])               done_res = neg_a_q ? -rem : rem;
    else                            done_res = (neg_a_q ^ neg_b_q) ? -quot : quot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d      = state_q;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    result       = '0;
    busy         = (state_q == BUSY);
    case (state_q)
      IDLE: if (start && !fast) state_d = special ? DONE : BUSY;
      BUSY: begin
        if (flush)                  state_d = IDLE;
        else if (cnt_q == CW'(1))   state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_n) begin
      stall_req = ~flush & ((start & ~fast) | (state_q == BUSY));
      if (state_q == DONE && !flush) begin
        result_valid = 1'b1;
        result       = done_res;
      end else if (start && fast) begin
        result_valid = 1'b1;
        result       = fast_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      opb_q         <= '0;
      f3_q          <= '0;
      neg_a_q       <= 1'b0;
      neg_b_q       <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      cnt_q         <= '0;
    end else if (start && !fast) begin
      acc_q         <= {{XLEN{1'b0}}, abs_a};
      opb_q         <= abs_b;
      f3_q          <= ex_funct3;
      neg_a_q       <= neg_a;
      neg_b_q       <= neg_b;
      special_q     <= special;
      special_res_q <= special_res;
      cnt_q         <= CW'(XLEN);
    end else if (state_q == BUSY) begin
      acc_q <= f3_q[2] ? div_nxt : mul_nxt;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule
